// File: rtl/addsub_rr_arbiter_if.sv
// Requester-side bundle for addsub_rr_arbiter: two request/response channels.
// The r0_ovf/r1_ovf signals exist only when ADDSUB_ARB_OVF_EN is defined.
interface addsub_rr_arbiter_if #(parameter int DATA_W = 4);
  logic              r0_valid, r0_ready, r0_mode, r0_rvalid, r0_rready, r0_cout;
  logic [DATA_W-1:0] r0_a, r0_b, r0_result;
  logic              r1_valid, r1_ready, r1_mode, r1_rvalid, r1_rready, r1_cout;
  logic [DATA_W-1:0] r1_a, r1_b, r1_result;
`ifdef ADDSUB_ARB_OVF_EN
  logic              r0_ovf, r1_ovf;
`endif

  modport master (
    output r0_valid, r0_a, r0_b, r0_mode, r0_rready,
    output r1_valid, r1_a, r1_b, r1_mode, r1_rready,
    input  r0_ready, r0_rvalid, r0_result, r0_cout,
    input  r1_ready, r1_rvalid, r1_result, r1_cout
`ifdef ADDSUB_ARB_OVF_EN
    , input r0_ovf, r1_ovf
`endif
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_mode, r0_rready,
    input  r1_valid, r1_a, r1_b, r1_mode, r1_rready,
    output r0_ready, r0_rvalid, r0_result, r0_cout,
    output r1_ready, r1_rvalid, r1_result, r1_cout
`ifdef ADDSUB_ARB_OVF_EN
    , output r0_ovf, r1_ovf
`endif
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sequencer sharing one 4-bit add/sub unit between r0 and r1.
// Define ADDSUB_ARB_OVF_EN to add registered signed-overflow outputs.
module addsub_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       mode,
  output logic [3:0] sum,
  output logic       cout
`ifdef ADDSUB_ARB_OVF_EN
  , output logic     ovf
`endif
);
  logic [3:0] bx;
  assign bx          = mode ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {4'd0, mode};
`ifdef ADDSUB_ARB_OVF_EN
  assign ovf = (a[3] == bx[3]) && (sum[3] != a[3]);
`endif
endmodule

module addsub_rr_arbiter #(
  parameter int DATA_W   = 4,
  parameter int INIT_PRI = 0
) (
  input  logic             clk,
  input  logic             rst,
  addsub_rr_arbiter_if.slave bus,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              pri, gnt, sel, accept, done;
  logic [DATA_W-1:0] a_q, b_q, sum, res0, res1;
  logic              mode_q, co, cout0, cout1;
`ifdef ADDSUB_ARB_OVF_EN
  logic              ov, ovf0, ovf1;
`endif

  // On contention pri breaks the tie; otherwise the lone requester wins.
  assign sel = (bus.r0_valid & bus.r1_valid) ? pri : bus.r1_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.r0_valid | bus.r1_valid) begin
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (gnt ? bus.r1_rready : bus.r0_rready) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.r0_ready  = accept & ~rst & ~sel;
  assign bus.r1_ready  = accept & ~rst &  sel;
  assign bus.r0_rvalid = (state == RESP) & ~gnt;
  assign bus.r1_rvalid = (state == RESP) &  gnt;
  assign busy          = (state != IDLE);

  addsub_unit u_alu (
    .a(a_q), .b(b_q), .mode(mode_q), .sum(sum), .cout(co)
`ifdef ADDSUB_ARB_OVF_EN
    , .ovf(ov)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pri    <= 1'(INIT_PRI);
      gnt    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      res0   <= '0;
      res1   <= '0;
      cout0  <= 1'b0;
      cout1  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      ovf0   <= 1'b0;
      ovf1   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        gnt    <= sel;
        a_q    <= sel ? bus.r1_a    : bus.r0_a;
        b_q    <= sel ? bus.r1_b    : bus.r0_b;
        mode_q <= sel ? bus.r1_mode : bus.r0_mode;
      end
      if (state == EXEC) begin
        if (gnt) begin
          res1  <= sum;
          cout1 <= co;
`ifdef ADDSUB_ARB_OVF_EN
          ovf1  <= ov;
`endif
        end else begin
          res0  <= sum;
          cout0 <= co;
`ifdef ADDSUB_ARB_OVF_EN
          ovf0  <= ov;
`endif
        end
      end
      // Priority rotates only when a result is consumed.
      if (done) pri <= ~gnt;
    end
  end

  assign bus.r0_result = res0;
  assign bus.r1_result = res1;
  assign bus.r0_cout   = cout0;
  assign bus.r1_cout   = cout1;
`ifdef ADDSUB_ARB_OVF_EN
  assign bus.r0_ovf    = ovf0;
  assign bus.r1_ovf    = ovf1;
`endif
endmodule
